// File: rtl/seven_segment_scan.sv
// Time-multiplexed hex display driver: decodes DIGITS nibbles, scans them over shared
// segment lines with registered outputs, and commits new values only on frame boundaries.
module seven_segment_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  lz_en,
    output logic                  a,
    output logic                  b,
    output logic                  c,
    output logic                  d,
    output logic                  e,
    output logic                  f,
    output logic                  g,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int T_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [T_W-1:0]   T_LAST   = T_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    // Segment pattern ordered a..g, a in the MSB, 1 = lit.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

    logic [T_W-1:0]       t_reg, t_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic                 tick_wrap, frame_wrap;

    logic [4*DIGITS-1:0]  shadow_value_reg, pend_value_reg;
    logic [DIGITS-1:0]    shadow_dp_reg, pend_dp_reg;
    logic                 shadow_lz_reg, pend_lz_reg;
    logic                 pend_valid_reg;

    logic [6:0]           seg_reg, seg_next;
    logic                 dp_reg, dp_next;
    logic [DIGITS-1:0]    an_reg, an_next;
    logic                 frame_start_reg, frame_start_next;

    // ---------------- scan counter ----------------
    assign tick_wrap  = (t_reg == T_LAST);
    assign frame_wrap = tick_wrap && (idx_reg == IDX_LAST);

    always_comb begin
        t_next   = t_reg + 1'b1;
        idx_next = idx_reg;
        if (tick_wrap) begin
            t_next   = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_reg   <= '0;
            idx_reg <= '0;
        end else begin
            t_reg   <= t_next;
            idx_reg <= idx_next;
        end
    end

    // ---------------- pending / shadow buffering ----------------
    // A load coinciding with the frame wrap bypasses pending so it shows next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value_reg <= '0;
            shadow_dp_reg    <= '0;
            shadow_lz_reg    <= 1'b0;
            pend_value_reg   <= '0;
            pend_dp_reg      <= '0;
            pend_lz_reg      <= 1'b0;
            pend_valid_reg   <= 1'b0;
        end else begin
            if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp_in;
                pend_lz_reg    <= lz_en;
                pend_valid_reg <= 1'b1;
            end
            if (frame_wrap) begin
                if (load) begin
                    shadow_value_reg <= value;
                    shadow_dp_reg    <= dp_in;
                    shadow_lz_reg    <= lz_en;
                end else if (pend_valid_reg) begin
                    shadow_value_reg <= pend_value_reg;
                    shadow_dp_reg    <= pend_dp_reg;
                    shadow_lz_reg    <= pend_lz_reg;
                end
                pend_valid_reg <= 1'b0;
            end
        end
    end

    // ---------------- leading-zero detection ----------------
    logic [DIGITS-1:0] nib_zero, upper_zero, blank, an_onehot;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_zero[gi]   = (shadow_value_reg[4*gi +: 4] == 4'h0);
            assign upper_zero[gi] = &nib_zero[DIGITS-1:gi];
            assign an_onehot[gi]  = (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = shadow_lz_reg && upper_zero[gi];
            end
        end
    endgenerate

    // ---------------- active digit select and decode ----------------
    logic [3:0] cur_nib;
    logic       cur_dp, cur_blank;
    logic [6:0] seg_lit;
    logic [DIGITS-1:0] an_lit;

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_onehot[i]) begin
                cur_nib   = shadow_value_reg[4*i +: 4];
                cur_dp    = shadow_dp_reg[i];
                cur_blank = blank[i];
            end
        end
    end

    // A blank digit keeps its enable only when its decimal point must still show.
    always_comb begin
        seg_lit          = cur_blank ? 7'b0000000 : decode_hex(cur_nib);
        an_lit           = (cur_blank && !cur_dp) ? '0 : an_onehot;
        seg_next         = seg_lit ^ {7{SEG_INV}};
        dp_next          = cur_dp ^ SEG_INV;
        an_next          = an_lit ^ {DIGITS{AN_INV}};
        frame_start_next = (idx_reg == '0) && (t_reg == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg         <= {7{SEG_INV}};
            dp_reg          <= SEG_INV;
            an_reg          <= {DIGITS{AN_INV}};
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            an_reg          <= an_next;
            frame_start_reg <= frame_start_next;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_reg;
    assign dp          = dp_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: directed steps plus random loads, checked against a
// frame-level model built from edge counts, a decode table and a highest-nonzero-digit rule.
module tb_seven_segment_scan;

    localparam int DIGITS  = 4;
    localparam int CLK_DIV = 4;
    localparam int FRAME   = DIGITS * CLK_DIV;

    logic        clk, rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load, lz_en;
    logic        a, b, c, d, e, f, g, dp, frame_start;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    seven_segment_scan #(
        .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load), .lz_en(lz_en),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_table [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    // Model state: edges since reset release, the displayed buffer and the pending buffer.
    int          n;
    logic [15:0] sh_val, pd_val;
    logic [3:0]  sh_dp, pd_dp;
    logic        sh_lz, pd_lz, pd_valid;

    task automatic model_reset();
        n = 0;
        sh_val = '0; sh_dp = '0; sh_lz = 1'b0;
        pd_val = '0; pd_dp = '0; pd_lz = 1'b0; pd_valid = 1'b0;
    endtask

    function automatic logic [12:0] observe();
        return {a, b, c, d, e, f, g, dp, an, frame_start};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (abcdefg_dp_an_fs) edge=%0d", tag, obs, exp, n);
        end
    endtask

    // One clock edge: predict what the edge displays, advance the model, then compare.
    task automatic tick(input string tag);
        int         digit, hi;
        logic [3:0] nib;
        logic [6:0] seg;
        logic       dpx, blank;
        logic [3:0] anx;
        logic [12:0] exp;
        @(posedge clk);
        digit = (n / CLK_DIV) % DIGITS;
        nib   = sh_val[digit*4 +: 4];
        hi    = -1;
        for (int i = 0; i < DIGITS; i++)
            if (sh_val[i*4 +: 4] != 4'h0) hi = i;
        blank = sh_lz && (digit > 0) && (digit > hi);
        seg   = blank ? 7'b0000000 : seg_table[nib];
        dpx   = sh_dp[digit];
        anx   = (blank && !dpx) ? 4'b1111 : ~(4'b0001 << digit);
        exp   = {seg, dpx, anx, ((n % FRAME) == 0)};
        if (load) begin
            pd_val = value; pd_dp = dp_in; pd_lz = lz_en; pd_valid = 1'b1;
        end
        if ((n % FRAME) == FRAME - 1) begin
            if (load) begin
                sh_val = value; sh_dp = dp_in; sh_lz = lz_en;
            end else if (pd_valid) begin
                sh_val = pd_val; sh_dp = pd_dp; sh_lz = pd_lz;
            end
            pd_valid = 1'b0;
        end
        n++;
        #1;
        check(tag, observe(), exp);
    endtask

    task automatic run(input int k, input string tag);
        repeat (k) tick(tag);
    endtask

    task automatic align(input int pos);
        while ((n % FRAME) != pos) tick("align");
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic lz, input string tag);
        value = v; dp_in = p; lz_en = lz; load = 1'b1;
        tick(tag);
        load = 1'b0; value = $urandom; dp_in = $urandom; lz_en = $urandom;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) v[i*4 +: 4] = 4'h0;
        return v;
    endfunction

    localparam logic [12:0] RESET_OUT = {7'b0000000, 1'b0, 4'b1111, 1'b0};
    localparam logic [12:0] FIRST_OUT = {7'b1111110, 1'b0, 4'b1110, 1'b1};

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_hold", observe(), RESET_OUT);
        end
        rst = 1'b0;

        // First frame after release: digit 0 shows "0" with frame_start.
        tick("first_edge");
        check("first_edge_const", observe(), FIRST_OUT);
        run(2 * FRAME - 1, "idle_scan");

        // Mid-frame load is held back until the next frame boundary.
        align(5);
        do_load(16'hA3F1, 4'b0100, 1'b0, "load_a3f1");
        run(2 * FRAME, "show_a3f1");

        // Two loads in one frame: only the later one is displayed.
        align(3);
        do_load(16'h1111, 4'b0000, 1'b0, "load_1111");
        align(9);
        do_load(16'h2222, 4'b0000, 1'b0, "load_2222");
        run(2 * FRAME, "show_2222");

        // Load on the wrap edge bypasses pending.
        align(FRAME - 1);
        do_load(16'h0009, 4'b0000, 1'b0, "load_wrap");
        run(2 * FRAME, "show_0009");

        // Leading-zero suppression with a decimal point on a blank digit.
        align(2);
        do_load(16'h0040, 4'b1000, 1'b1, "load_lz");
        run(2 * FRAME, "show_lz");
        align(7);
        do_load(16'h0000, 4'b0000, 1'b1, "load_lz_zero");
        run(2 * FRAME, "show_lz_zero");

        // Randomized loads, values biased toward zero nibbles.
        repeat (400) begin
            load  = ($urandom_range(0, 9) == 0);
            value = rand_val();
            dp_in = 4'($urandom);
            lz_en = 1'($urandom);
            tick("random");
        end
        load = 1'b0;

        // Asynchronous reset six edges into a frame with a pending load outstanding.
        align(1);
        do_load(16'h5678, 4'b0011, 1'b0, "load_before_rst");
        align(6);
        #2 rst = 1'b1;
        #1 check("async_rst_immediate", observe(), RESET_OUT);
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_midframe_hold", observe(), RESET_OUT);
        end
        rst = 1'b0;
        tick("after_rst_first");
        check("after_rst_first_const", observe(), FIRST_OUT);
        run(2 * FRAME, "after_rst_scan");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
Name: seven_segment_scan

Overview:
- Parameterised, time-multiplexed hex display driver that generalises the single-digit combinational seven-segment decoder to DIGITS digits.
- Decodes one 4-bit nibble per digit, scans the digits through shared a..g/dp lines plus per-digit enables, and buffers new values so they take effect only on a frame boundary.
- Adds per-digit decimal points, leading-zero suppression and selectable output polarity.
- Sits between the datapath and board I/O.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- CLK_DIV, 16, clock cycles each digit is displayed; legal value is 1 or more.
- SEG_ACTIVE_LOW, 0, 1 inverts a..g and dp at the output register.
- AN_ACTIVE_LOW, 1, 1 inverts an[] at the output register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active high.
- value  in  4*DIGITS  nibble i = value[4i+3:4i] is digit i; digit 0 is least significant.
- dp_in  in  DIGITS  decimal point request for digit i.
- load  in  1  capture value/dp_in/lz_en into the pending buffer.
- lz_en  in  1  leading-zero suppression enable, captured with load.
- a,b,c,d,e,f,g  out  1 each  segment drives, registered.
- dp  out  1  decimal point drive, registered.
- an  out  DIGITS  one-hot digit enable, registered.
- frame_start  out  1  one-cycle pulse on the first cycle digit 0 is shown in each frame.

Behaviour:
- Reset: clk single clock; rst asynchronous, active high.
  - Clears tick counter t, index idx, shadow and pending (value, dp, lz) and pending_valid.
  - Forces all outputs to the inactive level: a..g, dp and an all off at the selected polarity; frame_start=0.
- Every edge, scan counter: if t==CLK_DIV-1 then t<=0 and idx<=(idx==DIGITS-1)?0:idx+1; else t<=t+1.
- Output register: each edge it loads the decode of the pre-edge idx and shadow.
  - Outputs therefore lag idx by 1 cycle.
  - The first edge after reset release shows digit 0 with frame_start=1.
  - Each digit is held exactly CLK_DIV cycles; one frame is DIGITS*CLK_DIV cycles.
- frame_start is registered high exactly when the pre-edge state is idx==0 and t==0.
- Decode (abcdefg, 1=lit):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Active digit i: an[i] on, all other an bits off; dp = shadow dp bit i.
- Leading-zero suppression (shadow lz=1):
  - Digit i>0 is blank if its nibble and all higher nibbles are 0. Digit 0 is never blank.
  - A blank digit drives a..g off.
  - If its dp bit is 1, an[i] and dp are on; otherwise an is all off for that slot.
- Buffering:
  - load=1 on an edge writes pending and sets pending_valid.
  - Repeated loads within a frame overwrite pending; the last one wins.
- Commit: on the wrap edge (t==CLK_DIV-1 and idx==DIGITS-1), shadow takes one of three sources, then pending_valid clears:
  - load=1 on that same edge: the live inputs are written directly to shadow (bypass).
  - else pending_valid=1: shadow <= pending.
  - else: shadow unchanged.
- Shadow never changes mid-frame, so no digit ever displays a mix of old and new values.
- DIGITS=1: idx stays 0, every tick wrap is a frame wrap, an is 1 bit.
- Reset mid-frame: immediate return to the reset state. Pending content is lost; scanning restarts at digit 0.
- Polarity: applied only at the output register. Internal logic is active-high.

Test Plan:
- Reset, then release with DIGITS=4, CLK_DIV=4, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=1, nothing loaded:
  - During reset: a..g=0000000, dp=0, an=1111.
  - First edge after release: an=1110, abcdefg=1111110 (digit "0"), frame_start=1.
  - Each digit held 4 cycles; an sequence 1110, 1101, 1011, 0111, repeating every 16 cycles.
- load value=16'hA3F1, dp_in=4'b0100, lz_en=0, mid-frame:
  - Output unchanged until the next frame_start.
  - Then digits show 1=0110000, F=1000111, 3=1111001 with dp=1, A=1110111.
- Two loads in one frame (16'h1111, then 16'h2222):
  - Only 2=1101101 is displayed next frame; 1 never appears.
- load asserted on the wrap edge with 16'h0009:
  - The very next frame shows 9 on digit 0 (bypass); pending_valid=0 afterwards.
- lz_en=1, value=16'h0040, dp_in=4'b1000:
  - Digit 3: an active, a..g=0, dp=1.
  - Digit 2: an all off.
  - Digit 1 shows 4=0110011; digit 0 shows 0=1111110.
  - With value=16'h0000, only digit 0 is lit.
- Assert rst 6 cycles into a frame after a pending load:
  - Outputs go inactive immediately (asynchronous).
  - After release, digit 0 shows "0" with frame_start=1; the pending value is discarded.
